// File: rtl/div3_pkg.sv
// rtl/div3_pkg.sv - shared types and constants for the sequential divide-by-3 unit
//
// Contents:
//   state_t      FSM state encoding (IDLE, RUN, DONE)
//   res_t        2-bit mod-3 residue; encoding 3 is never legal
//   RES0..RES2   residue constants
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] res_t;

    localparam res_t RES0 = 2'd0;
    localparam res_t RES1 = 2'd1;
    localparam res_t RES2 = 2'd2;

endpackage

// File: rtl/div_3_seq_if.sv
// rtl/div_3_seq_if.sv - operand/result handshake bundle for div_3_seq
//
// Signals:
//   in_valid, in_ready, digit                   operand stream (producer -> block)
//   out_valid, out_ready, quotient, remainder,  result stream (block -> consumer)
//   div
// Modports:
//   master  testbench / surrounding logic side
//   slave   div_3_seq side
interface div_3_seq_if #(
    parameter int SIZE = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] digit;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] quotient;
    logic [1:0]      remainder;
    logic            div;

    modport master (
        output in_valid, digit, out_ready,
        input  in_ready, out_valid, quotient, remainder, div
    );

    modport slave (
        input  in_valid, digit, out_ready,
        output in_ready, out_valid, quotient, remainder, div
    );
endinterface

// File: rtl/div3_step.sv
// rtl/div3_step.sv - one MSB-first long-division step by 3
//
// Ports:
//   r       in   current residue (0..2)
//   b       in   next operand bit
//   r_next  out  (2*r + b) mod 3
//   q       out  quotient bit, (2*r + b) >= 3
module div3_step
    import div3_pkg::*;
(
    input  res_t r,
    input  logic b,
    output res_t r_next,
    output logic q
);

    always_comb begin
        r_next = RES0;
        q      = 1'b0;
        case (r)
            RES0: begin                        // t = b
                r_next = b ? RES1 : RES0;
                q      = 1'b0;
            end
            RES1: begin                        // t = 2 + b
                r_next = b ? RES0 : RES2;
                q      = b;
            end
            RES2: begin                        // t = 4 + b
                r_next = b ? RES2 : RES1;
                q      = 1'b1;
            end
            default: begin
                r_next = RES0;
                q      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/div_3_seq.sv
// rtl/div_3_seq.sv - iterative divide-by-3 with valid/ready on both sides
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of div_3_seq_if:
//          digit accepted on in_valid && in_ready (IDLE only); SIZE cycles
//          later quotient/remainder/div are presented with out_valid and held
//          until out_ready. Results persist after the handshake.
module div_3_seq
    import div3_pkg::*;
#(
    parameter int SIZE = 64
) (
    input logic         clk,
    input logic         rst_n,
    div_3_seq_if.slave  bus
);

    localparam int CW = $clog2(SIZE + 1);

    state_t          state;
    logic [SIZE-1:0] opnd;
    logic [SIZE-2:0] qacc;      // top bit of the running quotient is only needed on the final load
    res_t            res;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] quot_q;
    res_t            rem_q;
    logic            div_q;
    logic            out_valid_q;

    res_t            res_next;
    logic            q_bit;
    logic [SIZE-1:0] qacc_next;

    div3_step u_step (
        .r      (res),
        .b      (opnd[SIZE-1]),
        .r_next (res_next),
        .q      (q_bit)
    );

    assign qacc_next = {qacc, q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opnd        <= '0;
            qacc        <= '0;
            res         <= RES0;
            cnt         <= '0;
            quot_q      <= '0;
            rem_q       <= RES0;
            div_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        opnd  <= bus.digit;
                        qacc  <= '0;
                        res   <= RES0;
                        cnt   <= CW'(SIZE);
                        state <= RUN;
                    end
                end
                RUN: begin
                    opnd <= opnd << 1;
                    qacc <= qacc_next[SIZE-2:0];
                    res  <= res_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quot_q      <= qacc_next;
                        rem_q       <= res_next;
                        div_q       <= (res_next == RES0);
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div       = div_q;

    // Residue encoding 3 means the step function or the register was corrupted.
    residue_legal_a: assert property (@(posedge clk) disable iff (!rst_n) res != 2'd3);

endmodule
